// File: rtl/paicore_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// paicore_xfer_ctrl
//
// Transaction sequencer for the PAICORE send/receive loopback datapath.
// Latches one transfer request, drives the datapath enables and configuration,
// tracks the TX and RX completions, measures the duration of each phase and
// recovers the datapath with a bounded reset pulse after an abort.
//
// Optional feature macro: PAICORE_XFER_TIMEOUT_EN
//   defined   -> per-phase timeout (cfg_timeout, 0 disables) drives the FSM
//                into RECOVER with status 01 (TX) or 10 (RX).
//   undefined -> no timeout logic; cfg_timeout is ignored and only abort can
//                reach RECOVER.
// -----------------------------------------------------------------------------
module paicore_xfer_ctrl #(
    parameter int TIMEOUT_W  = 32,
    parameter int RST_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          cfg_send_len,
    input  logic [31:0]          cfg_frame_num,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           status,
    output logic [TIMEOUT_W-1:0] tx_cycles,
    output logic [TIMEOUT_W-1:0] rx_cycles,
    output logic                 dp_fork_enable,
    output logic [31:0]          dp_send_len,
    output logic [31:0]          dp_frame_num_max,
    output logic                 dp_rx_rcving,
    output logic                 dp_rst,
    input  logic                 dp_tx_done,
    input  logic                 dp_rx_done
);

    // Width of the recovery pulse counter; at least one bit even for RST_CYCLES=1.
    localparam int RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_CNT_W-1:0] RST_CNT_LAST = RST_CNT_W'(RST_CYCLES - 1);

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_TX_TMO = 2'b01;
    localparam logic [1:0] ST_RX_TMO = 2'b10;
    localparam logic [1:0] ST_ABORT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TX      = 3'd1,
        S_RX      = 3'd2,
        S_FIN     = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t                 state_reg;
    logic                   rx_seen_reg;
    logic [31:0]            send_len_reg;
    logic [31:0]            frame_num_reg;
    logic [TIMEOUT_W-1:0]   tx_cycles_reg;
    logic [TIMEOUT_W-1:0]   rx_cycles_reg;
    logic [1:0]             status_reg;
    logic [RST_CNT_W-1:0]   rst_cnt_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   fork_reg;
    logic                   rcving_reg;
    logic                   dp_rst_reg;

    // Phase counts including the current cycle, saturating at all-ones.
    logic [TIMEOUT_W-1:0]   tx_cycles_next;
    logic [TIMEOUT_W-1:0]   rx_cycles_next;
    logic                   tx_timeout;
    logic                   rx_timeout;

    // Saturating increment of both phase counters.
    always_comb begin
        tx_cycles_next = (&tx_cycles_reg) ? tx_cycles_reg : tx_cycles_reg + TIMEOUT_W'(1);
        rx_cycles_next = (&rx_cycles_reg) ? rx_cycles_reg : rx_cycles_reg + TIMEOUT_W'(1);
    end

`ifdef PAICORE_XFER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0]   timeout_reg;

    // A phase expires in the cycle whose count reaches the latched limit.
    always_comb begin
        tx_timeout = (timeout_reg != '0) && (tx_cycles_next == timeout_reg);
        rx_timeout = (timeout_reg != '0) && (rx_cycles_next == timeout_reg);
    end
`else
    logic                   cfg_timeout_unused;

    // Timeouts compiled out; cfg_timeout is deliberately left unconnected.
    always_comb begin
        tx_timeout         = 1'b0;
        rx_timeout         = 1'b0;
        cfg_timeout_unused = ^cfg_timeout;
    end
`endif

    // Transfer sequencer: state, latched configuration, counters and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            rx_seen_reg   <= 1'b0;
            send_len_reg  <= '0;
            frame_num_reg <= '0;
            tx_cycles_reg <= '0;
            rx_cycles_reg <= '0;
            status_reg    <= ST_OK;
            rst_cnt_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            fork_reg      <= 1'b0;
            rcving_reg    <= 1'b0;
            dp_rst_reg    <= 1'b0;
`ifdef PAICORE_XFER_TIMEOUT_EN
            timeout_reg   <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        send_len_reg  <= cfg_send_len;
                        frame_num_reg <= cfg_frame_num;
`ifdef PAICORE_XFER_TIMEOUT_EN
                        timeout_reg   <= cfg_timeout;
`endif
                        tx_cycles_reg <= '0;
                        rx_cycles_reg <= '0;
                        status_reg    <= ST_OK;
                        rx_seen_reg   <= 1'b0;
                        busy_reg      <= 1'b1;
                        if (cfg_send_len == 32'd0) begin
                            // Nothing to send: complete without touching the datapath.
                            state_reg <= S_FIN;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg  <= S_TX;
                            fork_reg   <= 1'b1;
                            rcving_reg <= 1'b1;
                        end
                    end
                end

                S_TX: begin
                    tx_cycles_reg <= tx_cycles_next;
                    if (dp_rx_done) begin
                        rx_seen_reg <= 1'b1;
                    end
                    if (dp_tx_done) begin
                        // Completion beats abort and timeout in the same cycle.
                        if (rx_seen_reg || dp_rx_done) begin
                            state_reg  <= S_FIN;
                            done_reg   <= 1'b1;
                            fork_reg   <= 1'b0;
                            rcving_reg <= 1'b0;
                        end else begin
                            state_reg <= S_RX;
                        end
                    end else if (abort || tx_timeout) begin
                        state_reg   <= S_RECOVER;
                        status_reg  <= abort ? ST_ABORT : ST_TX_TMO;
                        fork_reg    <= 1'b0;
                        rcving_reg  <= 1'b0;
                        dp_rst_reg  <= 1'b1;
                        rst_cnt_reg <= '0;
                    end
                end

                S_RX: begin
                    rx_cycles_reg <= rx_cycles_next;
                    if (dp_rx_done) begin
                        state_reg  <= S_FIN;
                        done_reg   <= 1'b1;
                        fork_reg   <= 1'b0;
                        rcving_reg <= 1'b0;
                    end else if (abort || rx_timeout) begin
                        state_reg   <= S_RECOVER;
                        status_reg  <= abort ? ST_ABORT : ST_RX_TMO;
                        fork_reg    <= 1'b0;
                        rcving_reg  <= 1'b0;
                        dp_rst_reg  <= 1'b1;
                        rst_cnt_reg <= '0;
                    end
                end

                S_FIN: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end

                S_RECOVER: begin
                    // Hold the datapath in reset, then report through FIN.
                    if (rst_cnt_reg == RST_CNT_LAST) begin
                        state_reg  <= S_FIN;
                        dp_rst_reg <= 1'b0;
                        done_reg   <= 1'b1;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg + RST_CNT_W'(1);
                    end
                end

                default: begin
                    state_reg  <= S_IDLE;
                    busy_reg   <= 1'b0;
                    fork_reg   <= 1'b0;
                    rcving_reg <= 1'b0;
                    dp_rst_reg <= 1'b0;
                end
            endcase
        end
    end

    assign busy             = busy_reg;
    assign done             = done_reg;
    assign status           = status_reg;
    assign tx_cycles        = tx_cycles_reg;
    assign rx_cycles        = rx_cycles_reg;
    assign dp_fork_enable   = fork_reg;
    assign dp_send_len      = send_len_reg;
    assign dp_frame_num_max = frame_num_reg;
    assign dp_rx_rcving     = rcving_reg;
    assign dp_rst           = dp_rst_reg;

endmodule

// File: tb/tb_paicore_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_paicore_xfer_ctrl
//
// Table-driven directed transfers, hand-written reset/busy sequences and
// randomized transfers checked against an event-ordering reference model.
// Honours PAICORE_XFER_TIMEOUT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_paicore_xfer_ctrl;

    localparam int TW   = 8;
    localparam int RSTC = 4;
    localparam int INF  = 100000;
`ifdef PAICORE_XFER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [31:0]   cfg_send_len;
    logic [31:0]   cfg_frame_num;
    logic [TW-1:0] cfg_timeout;
    logic          busy;
    logic          done;
    logic [1:0]    status;
    logic [TW-1:0] tx_cycles;
    logic [TW-1:0] rx_cycles;
    logic          dp_fork_enable;
    logic [31:0]   dp_send_len;
    logic [31:0]   dp_frame_num_max;
    logic          dp_rx_rcving;
    logic          dp_rst;
    logic          dp_tx_done;
    logic          dp_rx_done;

    paicore_xfer_ctrl #(.TIMEOUT_W(TW), .RST_CYCLES(RSTC)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .cfg_send_len     (cfg_send_len),
        .cfg_frame_num    (cfg_frame_num),
        .cfg_timeout      (cfg_timeout),
        .busy             (busy),
        .done             (done),
        .status           (status),
        .tx_cycles        (tx_cycles),
        .rx_cycles        (rx_cycles),
        .dp_fork_enable   (dp_fork_enable),
        .dp_send_len      (dp_send_len),
        .dp_frame_num_max (dp_frame_num_max),
        .dp_rx_rcving     (dp_rx_rcving),
        .dp_rst           (dp_rst),
        .dp_tx_done       (dp_tx_done),
        .dp_rx_done       (dp_rx_done)
    );

    always #5 clk = ~clk;

    // One transfer: stimulus (a/b/c = cycle after start of the tx_done,
    // rx_done and abort pulses, 0 = never) plus expected results.
    typedef struct {
        int len;
        int frame;
        int tmo;
        int a;
        int b;
        int c;
        int st;
        int txc;
        int rxc;
        int endc;     // last cycle with the datapath enabled (phase end)
        int recov;    // 1 when the transfer goes through RECOVER
        int done_at;  // cycle after start carrying the done pulse
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    int n_xfer = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int x);
        return (x > (1 << TW) - 1) ? (1 << TW) - 1 : x;
    endfunction

    function automatic int min3(input int x, input int y, input int z);
        int m;
        m = (x < y) ? x : y;
        return (m < z) ? m : z;
    endfunction

    // Reference model: orders the completion, abort and timeout events of
    // each phase; completion beats abort, abort beats timeout.
    function automatic vec_t model(input vec_t s);
        vec_t r;
        int ca, cc, cl, cb, cc2, cl2, re, te;
        r = s;
        r.st = 0; r.txc = 0; r.rxc = 0; r.recov = 0;
        if (s.len == 0) begin
            r.endc = 0;
            r.done_at = 1;
            return r;
        end
        ca = (s.a != 0) ? s.a : INF;
        cc = (s.c != 0) ? s.c : INF;
        cl = (TO_EN && s.tmo != 0) ? s.tmo : INF;
        if (ca <= cc && ca <= cl) begin
            r.txc = sat(ca);
            if (s.b != 0 && s.b <= ca) begin
                r.endc = ca;
                r.done_at = ca + 1;
                return r;
            end
            cb  = (s.b != 0) ? s.b : INF;
            cc2 = (s.c > ca) ? s.c : INF;
            cl2 = (cl == INF) ? INF : ca + s.tmo;
            re  = min3(cb, cc2, cl2);
            r.rxc  = sat(re - ca);
            r.endc = re;
            if (cb == re) begin
                r.done_at = re + 1;
            end else begin
                r.recov   = 1;
                r.st      = (cc2 == re) ? 3 : 2;
                r.done_at = re + RSTC + 1;
            end
        end else begin
            te = (cc < cl) ? cc : cl;
            r.txc     = sat(te);
            r.st      = (cc == te) ? 3 : 1;
            r.recov   = 1;
            r.endc    = te;
            r.done_at = te + RSTC + 1;
        end
        return r;
    endfunction

    // Drive one transfer from an idle DUT and check it cycle by cycle.
    task automatic run_xfer(input vec_t v, input bit noisy_start);
        logic [4:0] ev;
        logic [4:0] av;
        cfg_send_len  = v.len;
        cfg_frame_num = v.frame;
        cfg_timeout   = TW'(v.tmo);
        start         = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= v.done_at + 1; k++) begin
            ev = {k <= v.done_at, k == v.done_at,
                  v.len != 0 && k <= v.endc, v.len != 0 && k <= v.endc,
                  v.recov != 0 && k > v.endc && k <= v.endc + RSTC};
            av = {busy, done, dp_fork_enable, dp_rx_rcving, dp_rst};
            chk($sformatf("x%0d ctrl{busy,done,fork,rcv,rst}@%0d", n_xfer, k), 64'(av), 64'(ev));
            if (k == 1 || k == v.done_at) begin
                chk($sformatf("x%0d send_len@%0d", n_xfer, k), 64'(dp_send_len), 64'(v.len));
                chk($sformatf("x%0d frame_num@%0d", n_xfer, k), 64'(dp_frame_num_max), 64'(v.frame));
            end
            if (k >= v.done_at) begin
                chk($sformatf("x%0d status@%0d", n_xfer, k), 64'(status), 64'(v.st));
                chk($sformatf("x%0d tx_cycles@%0d", n_xfer, k), 64'(tx_cycles), 64'(v.txc));
                chk($sformatf("x%0d rx_cycles@%0d", n_xfer, k), 64'(rx_cycles), 64'(v.rxc));
            end
            if (k <= v.done_at) begin
                dp_tx_done = (k == v.a);
                dp_rx_done = (k == v.b);
                abort      = (k == v.c);
                if (noisy_start) begin
                    start         = 1'($urandom_range(0, 1));
                    cfg_send_len  = $urandom;
                    cfg_frame_num = $urandom;
                end
                tick();
            end
        end
        start      = 1'b0;
        abort      = 1'b0;
        dp_tx_done = 1'b0;
        dp_rx_done = 1'b0;
        $display("xfer %0d len=%0d tmo=%0d tx@%0d rx@%0d abort@%0d -> status=%0d tx=%0d rx=%0d done@%0d",
                 n_xfer, v.len, v.tmo, v.a, v.b, v.c, status, tx_cycles, rx_cycles, v.done_at);
        n_xfer++;
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_send_len = '0; cfg_frame_num = '0; cfg_timeout = '0;
        dp_tx_done = 1'b0; dp_rx_done = 1'b0;

        //        len frame tmo  a    b    c   st txc rxc end rec done
        tbl.push_back('{16, 16,  0, 20,  25,  0,  0, 20,  5, 25, 0, 26}); // nominal
        tbl.push_back('{16, 16,  0,  8,   3,  0,  0,  8,  0,  8, 0,  9}); // rx first
        tbl.push_back('{ 5,  7,  0,  5,   5,  0,  0,  5,  0,  5, 0,  6}); // both same cycle
        tbl.push_back('{ 0,  9,  0,  0,   0,  0,  0,  0,  0,  0, 0,  1}); // send_len = 0
        tbl.push_back('{ 8,  8,  0,  6,   0, 10,  3,  6,  4, 10, 1, 15}); // abort in RX
        tbl.push_back('{ 8,  8,  0,  6,  10, 10,  0,  6,  4, 10, 0, 11}); // abort vs rx_done
        tbl.push_back('{ 8,  8,  0,  0,   0,  4,  3,  4,  0,  4, 1,  9}); // abort in TX
        tbl.push_back('{ 8,  8,  0,  7,  12,  7,  0,  7,  5, 12, 0, 13}); // abort vs tx_done
        tbl.push_back('{ 4,  4,  0, 300, 302, 0,  0, 255, 2, 302, 0, 303}); // tx_cycles saturates
`ifdef PAICORE_XFER_TIMEOUT_EN
        tbl.push_back('{16, 16, 10,  0,   0,  0,  1, 10,  0, 10, 1, 15}); // TX timeout
        tbl.push_back('{16, 16, 10,  3,   0,  0,  2,  3, 10, 13, 1, 18}); // RX timeout
        tbl.push_back('{16, 16, 10, 10,  12,  0,  0, 10,  2, 12, 0, 13}); // completion beats timeout
`else
        tbl.push_back('{16, 16, 10,  0,   0, 30,  3, 30,  0, 30, 1, 35}); // timeout ignored
`endif

        // Reset state.
        tick(); tick();
        chk("reset_ctrl", 64'({busy, done, dp_fork_enable, dp_rx_rcving, dp_rst}), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_ctrl", 64'({busy, done, dp_fork_enable, dp_rx_rcving, dp_rst}), 64'd0);
        chk("idle_status", 64'(status), 64'd0);
        chk("idle_counters", 64'({tx_cycles, rx_cycles}), 64'd0);
        chk("idle_cfg", 64'({dp_send_len, dp_frame_num_max}), 64'd0);

        // Directed table.
        for (int i = 0; i < tbl.size(); i++) begin
            run_xfer(tbl[i], 1'b0);
        end

        // Reset in the middle of TX: everything clears, no done pulse.
        cfg_send_len = 32'd8; cfg_frame_num = 32'd8; cfg_timeout = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("midtx_busy", 64'({busy, dp_fork_enable}), 64'b11);
        chk("midtx_tx_cycles", 64'(tx_cycles), 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midtx_rst_ctrl", 64'({busy, done, dp_fork_enable, dp_rx_rcving, dp_rst}), 64'd0);
        chk("midtx_rst_regs", 64'({status, tx_cycles, rx_cycles}), 64'd0);
        chk("midtx_rst_cfg", 64'({dp_send_len, dp_frame_num_max}), 64'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("midtx_no_done@%0d", k), 64'({busy, done}), 64'd0);
        end
        $display("xfer %0d reset mid-TX -> busy=%0d done=%0d", n_xfer, busy, done);
        n_xfer++;
        run_xfer(tbl[0], 1'b0);

        // Randomized transfers with start spam while busy.
        for (int i = 0; i < 40; i++) begin
            rv.len   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1000));
            rv.frame = int'($urandom_range(0, 1000));
            rv.tmo   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(3, 40));
            rv.a     = int'($urandom_range(1, 30));
            rv.b     = int'($urandom_range(1, 40));
            rv.c     = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 45));
            run_xfer(model(rv), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
